// File: rtl/game_update_sequencer.sv
// Per-frame scheduler: on a qualified frame it walks latch -> pacman -> ghosts -> collision -> commit.
// Moore pulse outputs; each engine handshake is guarded by a per-WAIT timeout.
module game_update_sequencer #(
  parameter int N_GHOSTS       = 4,
  parameter int TICK_DIV       = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TICK_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_stb,
  input  logic                      enable,
  input  logic                      clear_err,
  output logic                      input_latch,
  output logic                      pac_start,
  input  logic                      pac_done,
  output logic                      ghost_start,
  output logic [$clog2(N_GHOSTS):0] ghost_idx,
  input  logic                      ghost_done,
  output logic                      coll_start,
  input  logic                      coll_done,
  output logic                      commit,
  output logic                      busy,
  output logic [TICK_W-1:0]         tick_count,
  output logic                      frame_overrun,
  output logic                      timeout_err
);

  localparam int GI_W  = $clog2(N_GHOSTS) + 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WC_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST  = WC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GI_W-1:0]  GHOST_LAST = GI_W'(N_GHOSTS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_PAC_START, S_PAC_WAIT, S_GHOST_START,
    S_GHOST_WAIT, S_COLL_START, S_COLL_WAIT, S_COMMIT
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              qualified, is_wait, wait_exp;
  logic              tmo_hit, ghost_clr, ghost_inc;

  assign qualified   = frame_stb & enable;
  assign is_wait     = (state == S_PAC_WAIT) || (state == S_GHOST_WAIT) || (state == S_COLL_WAIT);
  assign wait_exp    = (wait_cnt == WAIT_LAST);

  assign input_latch = (state == S_LATCH);
  assign pac_start   = (state == S_PAC_START);
  assign ghost_start = (state == S_GHOST_START);
  assign coll_start  = (state == S_COLL_START);
  assign commit      = (state == S_COMMIT);
  assign busy        = (state != S_IDLE);

  // A done coinciding with expiry takes the normal path, so tmo_hit needs done low.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    ghost_clr = 1'b0;
    ghost_inc = 1'b0;
    case (state)
      S_IDLE:        if (qualified && (div_cnt == DIV_LAST)) state_nxt = S_LATCH;
      S_LATCH:       state_nxt = S_PAC_START;
      S_PAC_START:   state_nxt = S_PAC_WAIT;
      S_PAC_WAIT: begin
        if (pac_done || wait_exp) begin
          tmo_hit   = ~pac_done;
          ghost_clr = 1'b1;
          state_nxt = S_GHOST_START;
        end
      end
      S_GHOST_START: state_nxt = S_GHOST_WAIT;
      S_GHOST_WAIT: begin
        if (ghost_done || wait_exp) begin
          tmo_hit = ~ghost_done;
          if (ghost_idx == GHOST_LAST) begin
            state_nxt = S_COLL_START;
          end else begin
            ghost_inc = 1'b1;
            state_nxt = S_GHOST_START;
          end
        end
      end
      S_COLL_START:  state_nxt = S_COLL_WAIT;
      S_COLL_WAIT: begin
        if (coll_done || wait_exp) begin
          tmo_hit   = ~coll_done;
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT:      state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      wait_cnt      <= '0;
      ghost_idx     <= '0;
      tick_count    <= '0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && qualified)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      // Leaving a WAIT (or never being in one) restarts the count for the next WAIT.
      wait_cnt <= (is_wait && (state_nxt == state)) ? wait_cnt + 1'b1 : '0;
      if (ghost_clr)
        ghost_idx <= '0;
      else if (ghost_inc)
        ghost_idx <= ghost_idx + 1'b1;
      if (state == S_COMMIT)
        tick_count <= tick_count + 1'b1;
      if (qualified && (state != S_IDLE))
        frame_overrun <= 1'b1;
      else if (clear_err)
        frame_overrun <= 1'b0;
      if (tmo_hit)
        timeout_err <= 1'b1;
      else if (clear_err)
        timeout_err <= 1'b0;
    end
  end

endmodule
